// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and default parameters for the UART TX arbiter
package uart_arb_pkg;
    typedef enum logic {IDLE, XFER} arb_state_t;
    localparam int          N_REQ_DEF   = 4;
    localparam logic [15:0] TIMEOUT_DEF = 16'd50000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search for the first set request after ptr
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    // scan ptr+1 .. ptr+N modulo N and keep the first hit
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin arbiter feeding one UART transmitter
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          N_REQ   = N_REQ_DEF,
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   s_valid,
    input  logic [8*N_REQ-1:0] s_data,
    input  logic [N_REQ-1:0]   s_last,
    output logic [N_REQ-1:0]   s_ready,
    output logic               o_e,
    input  logic               o_r,
    output logic [7:0]         o_d,
    output logic [N_REQ-1:0]   grant,
    output logic               timeout_err
);
    localparam int W = $clog2(N_REQ);

    arb_state_t   state, state_nxt;
    logic [W-1:0] owner, owner_nxt, ptr, ptr_nxt, pick;
    logic [15:0]  gap, gap_nxt;
    logic         found, tout_nxt, busy, fire;

    rr_pick #(.N(N_REQ), .W(W)) u_pick (
        .req   (s_valid),
        .ptr   (ptr),
        .idx   (pick),
        .found (found)
    );

    // owner port passes straight through to the UART; everything is quiet in IDLE
    always_comb begin
        busy           = (state == XFER);
        grant          = '0;
        grant[owner]   = busy;
        s_ready        = '0;
        s_ready[owner] = busy & o_r;
        o_e            = busy & s_valid[owner];
        o_d            = busy ? s_data[{owner, 3'b000} +: 8] : 8'h00;
        fire           = o_e & o_r;
    end

    // arbitration in IDLE; packet end or idle-gap timeout returns to IDLE
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        gap_nxt   = gap;
        tout_nxt  = 1'b0;
        if (state == IDLE) begin
            if (found) begin
                state_nxt = XFER;
                owner_nxt = pick;
                gap_nxt   = '0;
            end
        end else if (fire) begin
            gap_nxt = '0;
            if (s_last[owner]) begin
                state_nxt = IDLE;
                ptr_nxt   = owner;
            end
        end else if (!s_valid[owner]) begin
            gap_nxt = gap + 16'd1;
            if (gap_nxt == TIMEOUT) begin
                state_nxt = IDLE;
                ptr_nxt   = owner;
                tout_nxt  = 1'b1;
            end
        end
    end

    // all arbiter state; ptr resets to the last index so requester 0 wins first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= W'(N_REQ - 1);
            gap         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            ptr         <= ptr_nxt;
            gap         <= gap_nxt;
            timeout_err <= tout_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for the UART TX arbiter with TIMEOUT=10
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  s_valid = '0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_last = '0;
    logic [3:0]  s_ready;
    logic        o_e;
    logic        o_r = 1'b1;
    logic [7:0]  o_d;
    logic [3:0]  grant;
    logic        timeout_err;

    int          len[4];
    logic [7:0]  base[4];
    int          bcnt[4];
    bit          rep;
    logic [3:0]  g, sr;
    logic        oe, te;
    logic [7:0]  od;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16'd10)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .o_e         (o_e),
        .o_r         (o_r),
        .o_d         (o_d),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    task automatic load(input int k, input int l, input logic [7:0] b);
        len[k]  = l;
        base[k] = b;
        bcnt[k] = 0;
    endtask

    // one clock: drive sources at negedge, sample outputs, advance accepted bytes
    task automatic cyc(input logic [3:0] en, input logic r);
        @(negedge clk);
        o_r = r;
        for (int k = 0; k < 4; k++) begin
            s_valid[k]        = en[k] && (bcnt[k] < len[k]);
            s_data[8*k +: 8]  = base[k] + 8'(bcnt[k]);
            s_last[k]         = (bcnt[k] == len[k] - 1);
        end
        #1;
        g  = grant;
        sr = s_ready;
        oe = o_e;
        te = timeout_err;
        od = o_d;
        for (int k = 0; k < 4; k++) begin
            if (s_valid[k] && s_ready[k] && rstn) begin
                bcnt[k]++;
                if (rep && bcnt[k] == len[k]) bcnt[k] = 0;
            end
        end
    endtask

    task automatic do_reset();
        rep  = 0;
        rstn = 1'b0;
        for (int k = 0; k < 4; k++) load(k, 0, 8'h00);
        cyc(4'h0, 1'b1);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) load(k, 3, 8'h00);
        rep  = 0;
        rstn = 1'b0;
        cyc(4'hf, 1'b1);
        total_cnt += 4;
        if (g !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", g); else pass_cnt++;
        if (sr !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", sr); else pass_cnt++;
        if (oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", oe); else pass_cnt++;
        if (te !== 1'b0) $display("FAIL reset_tout: got %b want 0", te); else pass_cnt++;
        cyc(4'h0, 1'b1);
        rstn = 1'b1;
        cyc(4'h0, 1'b1);
        total_cnt++;
        if (g !== 4'b0000) $display("FAIL idle_grant: got %b want 0000", g); else pass_cnt++;
    endtask

    task automatic test_rr_pairs();
        logic [3:0] eg [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4,
                                4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4};
        logic [7:0] ed [16] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h20, 8'h21, 8'h22,
                                8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h20, 8'h21, 8'h22};
        do_reset();
        load(0, 3, 8'h00);
        load(2, 3, 8'h20);
        rep = 1;
        for (int c = 0; c < 16; c++) begin
            cyc(4'b0101, 1'b1);
            total_cnt += 2;
            if (g !== eg[c]) $display("FAIL rr_grant c%0d: got %b want %b", c, g, eg[c]); else pass_cnt++;
            if (oe !== (eg[c] != 0)) $display("FAIL rr_oe c%0d: got %b want %b", c, oe, eg[c] != 0); else pass_cnt++;
            if (eg[c] != 0) begin
                total_cnt += 2;
                if (od !== ed[c]) $display("FAIL rr_data c%0d: got %h want %h", c, od, ed[c]); else pass_cnt++;
                if (sr !== eg[c]) $display("FAIL rr_ready c%0d: got %b want %b", c, sr, eg[c]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        int nf = 0;
        logic [7:0] d[2];
        logic tseen = 1'b0;
        do_reset();
        load(1, 2, 8'h41);
        for (int c = 0; c < 10; c++) begin
            cyc(4'b0010, c % 2 == 0);
            if (oe && (c % 2 == 0)) begin
                if (nf < 2) d[nf] = od;
                nf++;
            end
            tseen |= te;
        end
        total_cnt += 5;
        if (nf !== 2) $display("FAIL bp_count: got %0d want 2", nf); else pass_cnt++;
        if (d[0] !== 8'h41) $display("FAIL bp_byte0: got %h want 41", d[0]); else pass_cnt++;
        if (d[1] !== 8'h42) $display("FAIL bp_byte1: got %h want 42", d[1]); else pass_cnt++;
        if (tseen !== 1'b0) $display("FAIL bp_tout: got %b want 0", tseen); else pass_cnt++;
        if (g !== 4'b0000) $display("FAIL bp_end_grant: got %b want 0000", g); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int tcnt = 0;
        do_reset();
        load(3, 5, 8'h30);
        load(0, 1, 8'h05);
        for (int c = 0; c < 16; c++) begin
            cyc(c < 2 ? 4'b1000 : 4'b0001, 1'b1);
            if (te) tcnt++;
            if (c == 1) begin
                total_cnt += 2;
                if (g !== 4'b1000) $display("FAIL to_owner: got %b want 1000", g); else pass_cnt++;
                if (od !== 8'h30 || oe !== 1'b1) $display("FAIL to_first: got %b/%h want 1/30", oe, od); else pass_cnt++;
            end
            if (c >= 2 && c <= 11) begin
                total_cnt += 2;
                if (g !== 4'b1000) $display("FAIL to_hold c%0d: got %b want 1000", c, g); else pass_cnt++;
                if (te !== 1'b0) $display("FAIL to_early c%0d: got %b want 0", c, te); else pass_cnt++;
            end
            if (c == 12) begin
                total_cnt += 2;
                if (te !== 1'b1) $display("FAIL to_pulse: got %b want 1", te); else pass_cnt++;
                if (g !== 4'b0000) $display("FAIL to_revoke: got %b want 0000", g); else pass_cnt++;
            end
            if (c == 13) begin
                total_cnt += 3;
                if (te !== 1'b0) $display("FAIL to_width: got %b want 0", te); else pass_cnt++;
                if (g !== 4'b0001) $display("FAIL to_next_grant: got %b want 0001", g); else pass_cnt++;
                if (od !== 8'h05) $display("FAIL to_next_data: got %h want 05", od); else pass_cnt++;
            end
        end
        total_cnt++;
        if (tcnt !== 1) $display("FAIL to_pulses: got %0d want 1", tcnt); else pass_cnt++;
    endtask

    task automatic test_no_interleave();
        logic [3:0] eg [9] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h2, 4'h2, 4'h0};
        do_reset();
        load(2, 4, 8'h20);
        load(1, 2, 8'h10);
        for (int c = 0; c < 9; c++) begin
            cyc(c == 0 ? 4'b0100 : 4'b0110, 1'b1);
            total_cnt++;
            if (g !== eg[c]) $display("FAIL ni_grant c%0d: got %b want %b", c, g, eg[c]); else pass_cnt++;
            if (c <= 5) begin
                total_cnt++;
                if (sr[1] !== 1'b0) $display("FAIL ni_ready1 c%0d: got %b want 0", c, sr[1]); else pass_cnt++;
            end
            if (c == 4 || c == 6 || c == 7) begin
                total_cnt++;
                if (od !== (c == 4 ? 8'h23 : c == 6 ? 8'h10 : 8'h11))
                    $display("FAIL ni_data c%0d: got %h want %h", c, od, c == 4 ? 8'h23 : c == 6 ? 8'h10 : 8'h11);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(0, 4, 8'h50);
        repeat (3) cyc(4'b0001, 1'b1);
        total_cnt += 2;
        if (oe !== 1'b1) $display("FAIL rm_pre_oe: got %b want 1", oe); else pass_cnt++;
        if (od !== 8'h51) $display("FAIL rm_pre_data: got %h want 51", od); else pass_cnt++;
        rstn = 1'b0;
        #1;
        total_cnt += 3;
        if (o_e !== 1'b0) $display("FAIL rm_oe: got %b want 0", o_e); else pass_cnt++;
        if (grant !== 4'b0000) $display("FAIL rm_grant: got %b want 0000", grant); else pass_cnt++;
        if (s_ready !== 4'b0000) $display("FAIL rm_ready: got %b want 0000", s_ready); else pass_cnt++;
        for (int k = 0; k < 4; k++) load(k, 1, 8'h60 + 8'(k * 16));
        cyc(4'hf, 1'b1);
        total_cnt++;
        if (g !== 4'b0000) $display("FAIL rm_held: got %b want 0000", g); else pass_cnt++;
        rstn = 1'b1;
        cyc(4'hf, 1'b1);
        total_cnt += 2;
        if (g !== 4'b0001) $display("FAIL rm_first: got %b want 0001", g); else pass_cnt++;
        if (od !== 8'h60) $display("FAIL rm_first_data: got %h want 60", od); else pass_cnt++;
    endtask

    task automatic test_single_bytes();
        logic [3:0] eg [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        logic [7:0] ed [10] = '{8'h00, 8'hA0, 8'h00, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA3, 8'h00, 8'hA0};
        do_reset();
        for (int k = 0; k < 4; k++) load(k, 1, 8'hA0 + 8'(k));
        rep = 1;
        for (int c = 0; c < 10; c++) begin
            cyc(4'hf, 1'b1);
            total_cnt += 2;
            if (g !== eg[c]) $display("FAIL sb_grant c%0d: got %b want %b", c, g, eg[c]); else pass_cnt++;
            if (oe !== (eg[c] != 0)) $display("FAIL sb_oe c%0d: got %b want %b", c, oe, eg[c] != 0); else pass_cnt++;
            if (eg[c] != 0) begin
                total_cnt++;
                if (od !== ed[c]) $display("FAIL sb_data c%0d: got %h want %h", c, od, ed[c]); else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_pairs();
        test_backpressure();
        test_timeout();
        test_no_interleave();
        test_reset_mid();
        test_single_bytes();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requester ports, legal range 2..8.
REQ-002 Parameter [15:0] TIMEOUT, default 16'd50000: maximum idle-gap cycles allowed mid-packet (legal range ≥1).
REQ-003 clk  input  1  clock.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  N_REQ  per-requester byte valid.
REQ-006 s_data  input  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 s_last  input  N_REQ  per-requester last-byte-of-packet flag, qualified by s_valid.
REQ-008 s_ready  output  N_REQ  per-requester byte accepted when s_valid[k] & s_ready[k].
REQ-009 o_e  output  1  byte enable toward the UART transmitter.
REQ-010 o_r  input  1  UART transmitter ready; a byte transfers when o_e & o_r.
REQ-011 o_d  output  8  byte toward the UART transmitter.
REQ-012 grant  output  N_REQ  one-hot current owner; all-zero when idle.
REQ-013 timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 The FSM SHALL have two states: IDLE and XFER.
REQ-015 In IDLE: o_e=0, s_ready=0, grant=0.
REQ-016 In IDLE with any s_valid bit set, the block SHALL select the first requester with s_valid set, searching round-robin from index (ptr+1) mod N_REQ, register it as owner, and enter XFER on the next cycle (1-cycle arbitration latency).
REQ-017 In XFER: grant=onehot(owner), o_e=s_valid[owner], o_d=s_data[owner], s_ready[owner]=o_r, and all other s_ready bits 0 (combinational pass-through).
REQ-018 In XFER, a transfer with s_last[owner]=1 SHALL set ptr=owner and return to IDLE on the next cycle.
REQ-019 Bytes of one packet SHALL never interleave with bytes of another requester.
REQ-020 Gap counter: cleared on XFER entry and on every transfer; increments each XFER cycle with s_valid[owner]=0; holds while s_valid[owner]=1 and o_r=0 (UART busy is not a stall).
REQ-021 When the gap counter reaches TIMEOUT, the block SHALL pulse timeout_err for one cycle, set ptr=owner, and return to IDLE; the partial packet is not completed.
REQ-022 A transfer in the same cycle the counter would reach TIMEOUT SHALL take priority; no timeout fires.
REQ-023 Requests changing while in XFER SHALL have no effect until the return to IDLE.
REQ-024 A single-byte packet (s_last on the first byte) SHALL occupy exactly 2 cycles of arbiter overhead (IDLE plus the XFER transfer cycle) when o_r=1.
REQ-025 Gap counter width SHALL be 16 bits and SHALL not wrap.

Reset
REQ-026 On rstn low: state=IDLE, ptr=N_REQ-1 (requester 0 wins first), owner=0, gap counter=0, timeout_err=0; hence o_e=0, s_ready=0, grant=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet immediately; no byte is presented after reset deassertion until a new arbitration.

Structure
REQ-028 Package uart_arb_pkg SHALL hold the FSM state enum (IDLE, XFER) and default constants N_REQ_DEF=4 and TIMEOUT_DEF=16'd50000.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs idx and found).
REQ-030 All sequential logic SHALL be in a single always block clocked on posedge clk with async negedge rstn.

Verification
REQ-031 Reset, then s_valid=4'b0101 held, each requester sending a 3-byte packet (last on byte 3), o_r=1 -> grant order 0,2,0,2; 3 contiguous bytes per grant.
REQ-032 Requester 1 sends 0x41,0x42 (last) while o_r toggles 1/0 each cycle -> o_d sequence 0x41,0x42 exactly once each; no timeout_err.
REQ-033 TIMEOUT=10; requester 3 sends one byte without s_last, then s_valid[3]=0 -> timeout_err pulses exactly 10 cycles after the last transfer; grant=0 the next cycle; a pending requester 0 is then granted.
REQ-034 Requester 2 in XFER and requester 1 asserts mid-packet -> requester 1's s_ready stays 0 until requester 2's last byte; then requester 1 is granted.
REQ-035 rstn pulsed low during byte 2 of a 4-byte packet -> o_e=0, grant=0 immediately; after release with s_valid=4'b1111, requester 0 is granted first.
REQ-036 Single-byte packets from all 4 requesters, o_r=1 -> grants 0,1,2,3,0 with one byte each and one IDLE cycle between grants.
